// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared types and constants for the multi-cycle CPU controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_MEM    = 4'd3,
        ST_WB     = 4'd4,
        ST_BRANCH = 4'd5,
        ST_JUMP   = 4'd6,
        ST_HALT   = 4'd7,
        ST_ERROR  = 4'd8
    } state_t;

    localparam logic [3:0] c_op_load  = 4'b0001;
    localparam logic [3:0] c_op_addi  = 4'b0111;
    localparam logic [3:0] c_op_store = 4'b1000;
    localparam logic [3:0] c_op_beq   = 4'b1001;
    localparam logic [3:0] c_op_bne   = 4'b1010;
    localparam logic [3:0] c_op_jump  = 4'b1110;
    localparam logic [3:0] c_op_halt  = 4'b1111;

    localparam logic [2:0] c_alu_op_0 = 3'd0;
    localparam logic [2:0] c_alu_add  = 3'd1;
    localparam logic [2:0] c_alu_sub  = 3'd2;
    localparam logic [2:0] c_alu_op_3 = 3'd3;
    localparam logic [2:0] c_alu_op_4 = 3'd4;
    localparam logic [2:0] c_alu_op_5 = 3'd5;
    localparam logic [2:0] c_alu_op_6 = 3'd6;
    localparam logic [2:0] c_alu_op_7 = 3'd7;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'd0,
        PC_SRC_ALUOUT = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_t;

    typedef enum logic [1:0] {
        SRC_B_RT     = 2'd0,
        SRC_B_ONE    = 2'd1,
        SRC_B_IMM    = 2'd2,
        SRC_B_BR_OFF = 2'd3
    } alu_src_b_t;

    typedef struct packed {
        logic rtype;
        logic load;
        logic addi;
        logic store;
        logic beq;
        logic bne;
        logic jump;
        logic halt;
    } op_class_t;

endpackage

`default_nettype wire

// File: rtl/mc_op_decode.sv
// ============================================================================
// Module      : mc_op_decode
// Description : Opcode to one-hot instruction class plus R-type ALU operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] op_code,
    output op_class_t  op_class,
    output logic [2:0] rtype_alu_op
);

    always_comb begin
        op_class = '0;
        unique case (op_code)
            c_op_load:  op_class.load  = 1'b1;
            c_op_addi:  op_class.addi  = 1'b1;
            c_op_store: op_class.store = 1'b1;
            c_op_beq:   op_class.beq   = 1'b1;
            c_op_bne:   op_class.bne   = 1'b1;
            c_op_jump:  op_class.jump  = 1'b1;
            c_op_halt:  op_class.halt  = 1'b1;
            default:    op_class.rtype = 1'b1;
        endcase
    end

    // Non-R-type opcodes fall through to add; the FSM ignores this value for them.
    always_comb begin
        rtype_alu_op = c_alu_add;
        case (op_code)
            4'b0010: rtype_alu_op = c_alu_sub;
            4'b0100: rtype_alu_op = c_alu_op_6;
            4'b0101: rtype_alu_op = c_alu_op_3;
            4'b0110: rtype_alu_op = c_alu_op_5;
            4'b1011: rtype_alu_op = c_alu_op_0;
            4'b1100: rtype_alu_op = c_alu_op_4;
            4'b1101: rtype_alu_op = c_alu_op_7;
            default: rtype_alu_op = c_alu_add;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : Multi-cycle control FSM with memory handshake and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TCW         = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] op_code,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       bus_error,
    output logic [3:0] state_o
);

    localparam bit             c_wd_on    = (MEM_TIMEOUT != 0);
    localparam logic [TCW-1:0] c_wd_limit = c_wd_on ? TCW'(MEM_TIMEOUT - 1) : '0;
    localparam logic [TCW-1:0] c_wd_max   = '1;

    state_t         r_state;
    state_t         w_next_state;
    logic [TCW-1:0] r_wd_cnt;
    op_class_t      w_cls;
    logic [2:0]     w_rtype_op;
    logic           w_mem_state;
    logic           w_timeout;

    mc_op_decode u_op_decode (
        .op_code      (op_code),
        .op_class     (w_cls),
        .rtype_alu_op (w_rtype_op)
    );

    assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEM);
    // An ack in the final allowed cycle takes priority over the timeout.
    assign w_timeout   = c_wd_on && (r_wd_cnt == c_wd_limit) && !mem_ack;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (mem_ack)        w_next_state = ST_DECODE;
                else if (w_timeout) w_next_state = ST_ERROR;
            end
            ST_DECODE: begin
                if (w_cls.halt)                   w_next_state = ST_HALT;
                else if (w_cls.jump)              w_next_state = ST_JUMP;
                else if (w_cls.beq || w_cls.bne)  w_next_state = ST_BRANCH;
                else                              w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_cls.load || w_cls.store) w_next_state = ST_MEM;
                else                           w_next_state = ST_WB;
            end
            ST_MEM: begin
                if (mem_ack)        w_next_state = w_cls.store ? ST_FETCH : ST_WB;
                else if (w_timeout) w_next_state = ST_ERROR;
            end
            ST_WB:     w_next_state = ST_FETCH;
            ST_BRANCH: w_next_state = ST_FETCH;
            ST_JUMP:   w_next_state = ST_FETCH;
            ST_HALT:   w_next_state = ST_HALT;
            ST_ERROR:  w_next_state = ST_ERROR;
            default:   w_next_state = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Cleared on entry to a memory-wait state, saturating while the wait lasts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if ((w_next_state != r_state) &&
                     ((w_next_state == ST_FETCH) || (w_next_state == ST_MEM))) begin
            r_wd_cnt <= '0;
        end else if (w_mem_state && !mem_ack && (r_wd_cnt != c_wd_max)) begin
            r_wd_cnt <= r_wd_cnt + TCW'(1);
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_RT;
        alu_op     = c_alu_op_0;
        halted     = 1'b0;
        bus_error  = 1'b0;
        state_o    = 4'd0;
        if (rst_n) begin
            state_o = r_state;
            case (r_state)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRC_B_ONE;
                    alu_op    = c_alu_add;
                    ir_write  = mem_ack;
                    pc_write  = mem_ack;
                end
                ST_DECODE: begin
                    alu_src_b = SRC_B_BR_OFF;
                    alu_op    = c_alu_add;
                end
                ST_EXEC: begin
                    alu_src_a = 1'b1;
                    if (w_cls.rtype) begin
                        alu_src_b = SRC_B_RT;
                        alu_op    = w_rtype_op;
                    end else begin
                        alu_src_b = SRC_B_IMM;
                        alu_op    = c_alu_add;
                    end
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = w_cls.store;
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = w_cls.rtype;
                    mem_to_reg = w_cls.load;
                end
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_RT;
                    alu_op    = c_alu_sub;
                    pc_src    = PC_SRC_ALUOUT;
                    pc_write  = (w_cls.beq && zero) || (w_cls.bne && !zero);
                end
                ST_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                end
                ST_HALT:  halted    = 1'b1;
                ST_ERROR: bus_error = 1'b1;
                default:  bus_error = 1'b1;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the 4-bit-opcode CPU datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Handles a req/ack memory handshake with a timeout watchdog.
- Drives all datapath enables, muxes and the ALU op from one state register.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ack before entering ERROR. A value of 0 disables the watchdog.
- TCW, 5: width of the timeout counter. Must satisfy 2^TCW > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_code  in  4  opcode from the external instruction register; stable from DECODE until the instruction completes
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ack  in  1  one-cycle memory completion; ignored while mem_req=0
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  write strobe, qualified by mem_req
- iord  out  1  address source: 0=PC, 1=ALUOut
- ir_write  out  1  instruction register load
- pc_write  out  1  PC load
- pc_src  out  2  PC source: 0=ALU result, 1=ALUOut (branch target), 2=jump target
- reg_write  out  1  register file write
- reg_dst  out  1  destination: 1=rd, 0=rt
- mem_to_reg  out  1  writeback source: 1=MDR, 0=ALUOut
- alu_src_a  out  1  ALU A input: 0=PC, 1=rs
- alu_src_b  out  2  ALU B input: 0=rt, 1=const 1, 2=sign-extended immediate, 3=branch offset
- alu_op  out  3  ALU operation code
- halted  out  1  high in HALT
- bus_error  out  1  high in ERROR
- state_o  out  4  current state encoding, for debug

Behaviour:
- Reset (rst_n=0, asynchronous): state=FETCH, timeout counter=0. While rst_n=0, all outputs are forced to 0. After release, FETCH outputs appear combinationally from the state register.
- All outputs are Moore-style functions of state, plus op_code and, in BRANCH, zero. Unlisted outputs are 0 in every state.
- Opcode classes:
  - LOAD: 0001
  - ADDI: 0111
  - STORE: 1000
  - BEQ: 1001
  - BNE: 1010
  - JUMP: 1110
  - HALT: 1111
  - R-type: all remaining opcodes.
- R-type alu_op:
  - 0010→2, 0100→6, 0101→3, 0110→5
  - 1011→0, 1100→4, 1101→7
  - all other R-type opcodes→1 (add)
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=1.
  - On mem_ack: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=1, computing the branch target into ALUOut. Next state by class:
  - HALT→HALT
  - JUMP→JUMP
  - BEQ/BNE→BRANCH
  - all others→EXEC
- EXEC: alu_src_a=1.
  - R-type: alu_src_b=0, alu_op from the table above, then WB.
  - ADDI/LOAD/STORE: alu_src_b=2, alu_op=1. ADDI→WB, LOAD/STORE→MEM.
- MEM: mem_req=1, iord=1, mem_we=1 for STORE.
  - On mem_ack: STORE→FETCH, LOAD→WB.
- WB: reg_write=1; reg_dst=1 only for R-type; mem_to_reg=1 only for LOAD. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=2, pc_src=1.
  - pc_write=(BEQ&zero)|(BNE&~zero). Then FETCH.
- JUMP: pc_write=1, pc_src=2, then FETCH.
- HALT and ERROR are terminal; only rst_n exits them.
  - HALT: halted=1.
  - ERROR: bus_error=1.
- Latency with mem_ack on the first request cycle:
  - R-type/ADDI: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BEQ/BNE/JUMP: 3 cycles
  - Each extra memory wait cycle adds 1.
- Watchdog:
  - The counter clears on entering FETCH or MEM.
  - It increments each cycle in those states while mem_ack=0.
  - When count==MEM_TIMEOUT-1 and mem_ack=0, the next state is ERROR.
  - If mem_ack arrives in that same cycle, ack wins and normal flow continues.
  - The counter saturates and never wraps.
- Reset mid-wait: mem_req drops immediately and the FSM restarts in FETCH with the counter cleared.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encoding: FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, HALT, ERROR
  - opcode constants
  - alu_op codes
  - pc_src and alu_src_b enumerations
- Sub-module mc_op_decode (combinational): op_code → class one-hot plus R-type alu_op. It is shared by the FSM next-state logic and output logic.

Test Plan:
1. R-type: op 0101, ack on the first cycle → 4 cycles total; alu_op=3 in EXEC; reg_write=1 and reg_dst=1 in WB; back in FETCH on cycle 5.
2. LOAD: op 0001, ack delayed 2 cycles in FETCH and 1 in MEM → 8 cycles total; WB has mem_to_reg=1 and reg_dst=0; mem_we stays 0 throughout.
3. Branches:
   - BEQ (1001), zero=1 → pc_write=1, pc_src=1 in BRANCH.
   - BNE (1010), zero=1 → pc_write=0.
   - Each takes 3 cycles.
4. Watchdog: MEM_TIMEOUT=4, STORE with no ack in MEM → ERROR after 4 MEM cycles with bus_error=1 held; mem_ack asserted on the 4th cycle instead → no error.
5. HALT: op 1111 → halted=1 from cycle 3 and mem_req stays 0 for 20 cycles; a subsequent rst_n pulse returns to FETCH.
6. Asynchronous reset asserted mid-MEM, between clock edges → outputs go to 0 immediately; after release, FETCH drives mem_req=1 and iord=0.
